// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 8-digit 7-segment scan driver with double-buffered display data
//
// Ports:
//   clk          single clock, all state on rising edge
//   rst          asynchronous active-high reset
//   digits_in    eight 4-bit codes, digit i at [4i+3:4i], digit 0 leftmost
//   dots_in      decimal point per digit, bit i lights DP of digit i
//   load         one-cycle strobe capturing digits_in/dots_in into the shadow buffer
//   bright       brightness, 0 dimmest .. 15 full
//   cs           active-low one-hot digit select
//   seg          active-low segments {dp,g,f,e,d,c,b,a}
//   frame_start  one-cycle pulse when the outputs show digit 0, slot cycle 0
//   pending      shadow holds data not yet moved to the active buffer

module seg_scan_driver #(
    parameter int F_CLK  = 50000000,
    parameter int F_SCAN = 8000,
    parameter int BLANK  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dots_in,
    input  logic        load,
    input  logic [3:0]  bright,
    output logic [7:0]  cs,
    output logic [7:0]  seg,
    output logic        frame_start,
    output logic        pending
);

    localparam int DIV  = F_CLK / F_SCAN;
    localparam int SC_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(DIV - 1);
    localparam logic [31:0]     BLANK_U = 32'(BLANK);
    localparam logic [31:0]     ON_SPAN = 32'(DIV - BLANK);

    logic [SC_W-1:0] sc;
    logic [2:0]      p;
    // Holds off the scan for one edge after reset so the first edge only
    // arms the counters and frame_start first appears after the second edge.
    logic            run;

    logic [31:0]     shadow_dig;
    logic [7:0]      shadow_dot;
    logic [31:0]     active_dig;
    logic [7:0]      active_dot;

    logic [31:0]     sc_ext;
    logic [31:0]     on_len;
    logic            lit;
    logic            xfer;
    logic [3:0]      cur_code;
    logic            cur_dot;

    function automatic logic [6:0] decode7(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign sc_ext   = {{(32 - SC_W){1'b0}}, sc};
    // Lit window length scales the non-blanked part of the slot by (bright+1)/16.
    assign on_len   = (ON_SPAN * ({28'd0, bright} + 32'd1)) >> 4;
    assign lit      = (sc_ext >= BLANK_U) && (sc_ext < (BLANK_U + on_len));
    // Active buffer only changes at the last cycle of digit 7 so a frame
    // never shows a mix of old and new data.
    assign xfer     = run && (sc == SC_LAST) && (p == 3'd7) && pending;
    assign cur_code = active_dig[{p, 2'b00} +: 4];
    assign cur_dot  = active_dot[p];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc          <= '0;
            p           <= '0;
            run         <= 1'b0;
            shadow_dig  <= 32'hFFFF_FFFF;
            shadow_dot  <= 8'h00;
            active_dig  <= 32'hFFFF_FFFF;
            active_dot  <= 8'h00;
            pending     <= 1'b0;
            cs          <= 8'hFF;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dot <= dots_in;
            end

            // A load on the transfer edge keeps pending set: the new data
            // is still waiting in the shadow.
            if (load) begin
                pending <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end

            if (xfer) begin
                active_dig <= shadow_dig;
                active_dot <= shadow_dot;
            end

            if (!run) begin
                run         <= 1'b1;
                cs          <= 8'hFF;
                seg         <= 8'hFF;
                frame_start <= 1'b0;
            end else begin
                if (sc == SC_LAST) begin
                    sc <= '0;
                    p  <= p + 3'd1;
                end else begin
                    sc <= sc + 1'b1;
                end

                if (lit) begin
                    cs  <= ~(8'd1 << p);
                    seg <= ~{cur_dot, decode7(cur_code)};
                end else begin
                    cs  <= 8'hFF;
                    seg <= 8'hFF;
                end
                frame_start <= (p == 3'd0) && (sc == '0);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver against a tick-based display model

module tb_seg_scan_driver;

    localparam int DIV   = 20;
    localparam int BLANK = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk;
    logic        rst;
    logic [31:0] digits_in;
    logic [7:0]  dots_in;
    logic        load;
    logic [3:0]  bright;
    logic [7:0]  cs;
    logic [7:0]  seg;
    logic        frame_start;
    logic        pending;

    int n_cmp;
    int n_fail;

    seg_scan_driver #(
        .F_CLK  (200),
        .F_SCAN (10),
        .BLANK  (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dots_in     (dots_in),
        .load        (load),
        .bright      (bright),
        .cs          (cs),
        .seg         (seg),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] code);
        case (code)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Reference model: one frame-position tick (0..FRAME-1) gives digit and slot phase.
    logic        m_started;
    int          m_tick;
    logic [31:0] m_sh_d;
    logic [7:0]  m_sh_dot;
    logic [31:0] m_ac_d;
    logic [7:0]  m_ac_dot;
    logic        m_pending;
    logic [7:0]  exp_cs;
    logic [7:0]  exp_seg;
    logic        exp_fs;

    always @(posedge clk or posedge rst) begin
        int slot;
        int phase;
        int on_len;
        if (rst) begin
            m_started <= 1'b0;
            m_tick    <= 0;
            m_sh_d    <= 32'hFFFF_FFFF;
            m_sh_dot  <= 8'h00;
            m_ac_d    <= 32'hFFFF_FFFF;
            m_ac_dot  <= 8'h00;
            m_pending <= 1'b0;
            exp_cs    <= 8'hFF;
            exp_seg   <= 8'hFF;
            exp_fs    <= 1'b0;
        end else begin
            if (load) begin
                m_sh_d    <= digits_in;
                m_sh_dot  <= dots_in;
                m_pending <= 1'b1;
            end
            if (!m_started) begin
                m_started <= 1'b1;
                exp_cs    <= 8'hFF;
                exp_seg   <= 8'hFF;
                exp_fs    <= 1'b0;
            end else begin
                slot   = m_tick / DIV;
                phase  = m_tick % DIV;
                on_len = ((DIV - BLANK) * (int'(bright) + 1)) / 16;
                if (phase >= BLANK && phase < BLANK + on_len) begin
                    exp_cs  <= ~(8'd1 << slot);
                    exp_seg <= ~{m_ac_dot[slot], seg7(m_ac_d[slot*4 +: 4])};
                end else begin
                    exp_cs  <= 8'hFF;
                    exp_seg <= 8'hFF;
                end
                exp_fs <= (m_tick == 0);
                if (m_tick == FRAME - 1 && m_pending) begin
                    m_ac_d   <= m_sh_d;
                    m_ac_dot <= m_sh_dot;
                    if (!load) m_pending <= 1'b0;
                end
                m_tick <= (m_tick + 1) % FRAME;
            end
        end
    end

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cs, seg, frame_start, pending} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async got cs=%h seg=%h fs=%b pend=%b exp cs=ff seg=ff fs=0 pend=0", cs, seg, frame_start, pending);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (frame_start !== 1'b0 || cs !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_edge1 got fs=%b cs=%h exp fs=0 cs=ff", frame_start, cs);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_edge2_fs got %b exp 1", frame_start);
        end
    endtask

    task automatic test_idle();
        int since;
        int pulses;
        since  = 0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            since++;
            n_cmp++;
            if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                n_fail++;
                $display("FAIL idle_model t=%0t got cs=%h seg=%h fs=%b pend=%b exp cs=%h seg=%h fs=%b pend=%b",
                         $time, cs, seg, frame_start, pending, exp_cs, exp_seg, exp_fs, m_pending);
            end
            n_cmp++;
            if (seg !== 8'hFF || $countones(~cs) > 1) begin
                n_fail++;
                $display("FAIL idle_blank t=%0t got cs=%h seg=%h exp seg=ff cs one-hot-low", $time, cs, seg);
            end
            if (frame_start === 1'b1) begin
                pulses++;
                n_cmp++;
                if (since !== FRAME) begin
                    n_fail++;
                    $display("FAIL idle_fs_period got %0d exp %0d", since, FRAME);
                end
                since = 0;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL idle_fs_count got %0d exp 1", pulses);
        end
    endtask

    task automatic test_load_full();
        bit found;
        int n0;
        int n2;
        int first0;
        @(negedge clk);
        digits_in = 32'h7654_3210;
        dots_in   = 8'h24;
        bright    = 4'd15;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_cmp++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL load_pending_set got %b exp 1", pending);
        end
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                n_fail++;
                $display("FAIL load_wait_model t=%0t got cs=%h seg=%h fs=%b pend=%b exp cs=%h seg=%h fs=%b pend=%b",
                         $time, cs, seg, frame_start, pending, exp_cs, exp_seg, exp_fs, m_pending);
            end
            if (frame_start === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL load_frame_boundary got found=%b pend=%b exp found=1 pend=0", found, pending);
        end
        n0     = 0;
        n2     = 0;
        first0 = -1;
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                n_fail++;
                $display("FAIL load_frame_model t=%0t got cs=%h seg=%h fs=%b pend=%b exp cs=%h seg=%h fs=%b pend=%b",
                         $time, cs, seg, frame_start, pending, exp_cs, exp_seg, exp_fs, m_pending);
            end
            if (cs === 8'hFE) begin
                n0++;
                if (first0 < 0) first0 = i;
                n_cmp++;
                if (seg !== 8'hC0) begin
                    n_fail++;
                    $display("FAIL load_digit0_seg got %h exp c0", seg);
                end
            end
            if (cs === 8'hFB) begin
                n2++;
                n_cmp++;
                if (seg !== 8'h24) begin
                    n_fail++;
                    $display("FAIL load_digit2_seg got %h exp 24", seg);
                end
            end
        end
        n_cmp++;
        if (n0 !== 16 || first0 !== 4 || n2 !== 16) begin
            n_fail++;
            $display("FAIL load_lit_len got n0=%0d first0=%0d n2=%0d exp 16 4 16", n0, first0, n2);
        end
    endtask

    task automatic test_bright();
        int vals[4];
        int cnt[8];
        int first0;
        bit found;
        logic [7:0] sel;
        vals[0] = 0;
        vals[1] = 7;
        vals[2] = int'($urandom_range(1, 14));
        vals[3] = int'($urandom_range(0, 15));
        foreach (vals[k]) begin
            @(negedge clk);
            bright = 4'(vals[k]);
            found  = 0;
            for (int i = 0; i < 400 && !found; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                    n_fail++;
                    $display("FAIL bright_wait_model t=%0t got cs=%h seg=%h exp cs=%h seg=%h", $time, cs, seg, exp_cs, exp_seg);
                end
                if (frame_start === 1'b1) found = 1;
            end
            n_cmp++;
            if (!found) begin
                n_fail++;
                $display("FAIL bright_wait_fs got none exp frame_start");
            end
            foreach (cnt[d]) cnt[d] = 0;
            first0 = -1;
            for (int i = 1; i < FRAME; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                    n_fail++;
                    $display("FAIL bright_frame_model t=%0t got cs=%h seg=%h exp cs=%h seg=%h", $time, cs, seg, exp_cs, exp_seg);
                end
                for (int d = 0; d < 8; d++) begin
                    sel = ~(8'd1 << d);
                    if (cs === sel) cnt[d]++;
                end
                if (cs === 8'hFE && first0 < 0) first0 = i;
            end
            for (int d = 0; d < 8; d++) begin
                n_cmp++;
                if (cnt[d] !== vals[k] + 1) begin
                    n_fail++;
                    $display("FAIL bright_lit_cycles b=%0d digit=%0d got %0d exp %0d", vals[k], d, cnt[d], vals[k] + 1);
                end
            end
            n_cmp++;
            if (first0 !== BLANK) begin
                n_fail++;
                $display("FAIL bright_first_lit b=%0d got %0d exp %0d", vals[k], first0, BLANK);
            end
        end
    endtask

    task automatic test_codes();
        logic [31:0] d;
        bit found;
        int seen3;
        int seen5;
        for (int i = 0; i < 8; i++) d[i*4 +: 4] = 4'($urandom_range(0, 9));
        d[15:12] = 4'hA;
        d[23:20] = 4'hC;
        @(negedge clk);
        digits_in = d;
        dots_in   = 8'($urandom) & 8'hD7;
        bright    = 4'($urandom_range(0, 15));
        load      = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL codes_wait_fs got none exp frame_start");
        end
        seen3 = 0;
        seen5 = 0;
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                n_fail++;
                $display("FAIL codes_model t=%0t got cs=%h seg=%h exp cs=%h seg=%h", $time, cs, seg, exp_cs, exp_seg);
            end
            if (cs === 8'hF7) begin
                seen3++;
                n_cmp++;
                if (seg !== 8'hBF) begin
                    n_fail++;
                    $display("FAIL codes_dash got %h exp bf", seg);
                end
            end
            if (cs === 8'hDF) begin
                seen5++;
                n_cmp++;
                if (seg !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL codes_blank got %h exp ff", seg);
                end
            end
        end
        n_cmp++;
        if (seen3 < 1 || seen5 < 1) begin
            n_fail++;
            $display("FAIL codes_seen got d3=%0d d5=%0d exp >=1 each", seen3, seen5);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        bit found;
        int hits;
        a = $urandom;
        b = $urandom;
        a[3:0] = 4'h1;
        b[3:0] = 4'h8;
        @(negedge clk);
        bright    = 4'd15;
        digits_in = a;
        dots_in   = 8'h00;
        load      = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_started && m_pending && m_tick == FRAME - 1) begin
                found = 1;
            end else begin
                @(negedge clk);
                n_cmp++;
                if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                    n_fail++;
                    $display("FAIL b2b_wait_model t=%0t got cs=%h seg=%h pend=%b exp cs=%h seg=%h pend=%b", $time, cs, seg, pending, exp_cs, exp_seg, m_pending);
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL b2b_wait_xfer got none exp transfer edge");
        end
        digits_in = b;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_cmp++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pending_kept got %b exp 1", pending);
        end
        for (int f = 0; f < 2; f++) begin
            hits = 0;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                    n_fail++;
                    $display("FAIL b2b_frame_model t=%0t got cs=%h seg=%h pend=%b exp cs=%h seg=%h pend=%b", $time, cs, seg, pending, exp_cs, exp_seg, m_pending);
                end
                if (cs === 8'hFE) begin
                    hits++;
                    n_cmp++;
                    if (seg !== ((f == 0) ? 8'hF9 : 8'h80)) begin
                        n_fail++;
                        $display("FAIL b2b_digit0 frame=%0d got %h exp %h", f, seg, (f == 0) ? 8'hF9 : 8'h80);
                    end
                end
                if (f == 0 && i == FRAME / 2) begin
                    n_cmp++;
                    if (pending !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_pending_mid got %b exp 1", pending);
                    end
                end
            end
            n_cmp++;
            if (hits !== 16 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_frame_end frame=%0d got hits=%0d pend=%b exp 16 0", f, hits, pending);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c;
        bit found;
        c = $urandom;
        c[23:20] = 4'h3;
        @(negedge clk);
        bright    = 4'd15;
        digits_in = c;
        dots_in   = 8'h00;
        load      = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) found = 1;
        end
        digits_in = $urandom;
        load      = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_tick == 5 * DIV + 10) found = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found || cs !== 8'hDF || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre got found=%b cs=%h pend=%b exp 1 df 1", found, cs, pending);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cs, seg, frame_start, pending} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_async got cs=%h seg=%h fs=%b pend=%b exp ff ff 0 0", cs, seg, frame_start, pending);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cs, seg, frame_start, pending} !== {exp_cs, exp_seg, exp_fs, m_pending}) begin
                n_fail++;
                $display("FAIL rmid_model t=%0t got cs=%h seg=%h pend=%b exp cs=%h seg=%h pend=%b", $time, cs, seg, pending, exp_cs, exp_seg, m_pending);
            end
            n_cmp++;
            if (seg !== 8'hFF || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_blank t=%0t got seg=%h pend=%b exp ff 0", $time, seg, pending);
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b0;
        digits_in = 32'h0;
        dots_in   = 8'h0;
        load      = 1'b0;
        bright    = 4'd15;
        n_cmp     = 0;
        n_fail    = 0;
        test_reset();
        test_idle();
        test_load_full();
        test_bright();
        test_codes();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
